// File: rtl/multicycle_control_sequencer_if.sv
// Control bundle between the LEGv8 multi-cycle sequencer (master) and the datapath (slave).
// Optional illegal_op line exists only when MC_ILLEGAL_TRAP_EN is defined.
interface multicycle_control_sequencer_if #(
  parameter int RETIRE_W = 32
);
  logic                enable;
  logic [9:0]          opcode;
  logic                zero;
  logic                mem_ack;
  logic                pc_write;
  logic                pc_src;
  logic                ir_write;
  logic                reg_write_rf;
  logic                mem_read_dm;
  logic                mem_write_dm;
  logic                mux2;
  logic                mux3;
  logic [2:0]          alu_op;
  logic                branch;
  logic                mem_err;
  logic [RETIRE_W-1:0] retired;
  logic [2:0]          state_dbg;
`ifdef MC_ILLEGAL_TRAP_EN
  logic                illegal_op;
`endif

  // Memory handshake: mem_read_dm/mem_write_dm act as valid and stay high, with
  // address/data selects stable, until mem_ack (ready) is sampled high on a rising
  // edge; the transfer completes on that edge. mem_ack is ignored outside MEM.
  modport master (
    input  enable, opcode, zero, mem_ack,
`ifdef MC_ILLEGAL_TRAP_EN
    output illegal_op,
`endif
    output pc_write, pc_src, ir_write, reg_write_rf, mem_read_dm, mem_write_dm,
    output mux2, mux3, alu_op, branch, mem_err, retired, state_dbg
  );

  modport slave (
    output enable, opcode, zero, mem_ack,
`ifdef MC_ILLEGAL_TRAP_EN
    input  illegal_op,
`endif
    input  pc_write, pc_src, ir_write, reg_write_rf, mem_read_dm, mem_write_dm,
    input  mux2, mux3, alu_op, branch, mem_err, retired, state_dbg
  );
endinterface

// File: rtl/multicycle_control_sequencer.sv
// Multi-cycle LEGv8 control FSM: FETCH/DECODE/EXEC/MEM/WB with memory-ack timeout
// and retired-instruction counter. Define MC_ILLEGAL_TRAP_EN to halt on illegal opcodes.
module multicycle_control_sequencer #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int RETIRE_W     = 32
) (
  input logic                           clk,
  input logic                           reset,
  multicycle_control_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_ADDI, C_LDUR, C_STUR, C_CBZ, C_ILL
  } cls_t;

  function automatic cls_t decode_cls(input logic [9:0] op);
    cls_t c;
    casez (op)
      10'b1000101100, 10'b1100101100,
      10'b1000101000, 10'b1010101000: c = C_R;
      10'b1001000100:                 c = C_ADDI;
      10'b1111100001:                 c = C_LDUR;
      10'b1111100000:                 c = C_STUR;
      10'b10110100??:                 c = C_CBZ;
      default:                        c = C_ILL;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] decode_alu(input logic [9:0] op);
    logic [2:0] a;
    casez (op)
      10'b1100101100: a = 3'b110;
      10'b1000101000: a = 3'b000;
      10'b1010101000: a = 3'b001;
      10'b10110100??: a = 3'b111;
      10'b1000101100, 10'b1001000100,
      10'b1111100001, 10'b1111100000: a = 3'b010;
      default:        a = 3'b000;
    endcase
    return a;
  endfunction

  state_t              state, state_nx;
  logic [9:0]          op_q;
  logic [7:0]          wait_cnt;
  logic [RETIRE_W-1:0] retired_q;
  logic                mem_err_q;
  logic                retire_now;
  logic                timeout;
  state_t              eoi_state;
  cls_t                cls;
  cls_t                live_cls;
  logic [2:0]          alu_q;
  logic                imm_sel;

  assign cls      = decode_cls(op_q);
  assign live_cls = decode_cls(bus.opcode);
  assign alu_q    = decode_alu(op_q);
  assign imm_sel  = (cls == C_ADDI) || (cls == C_LDUR) || (cls == C_STUR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      op_q      <= '0;
      wait_cnt  <= '0;
      retired_q <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state     <= state_nx;
      mem_err_q <= timeout;
      if (state == S_DECODE) op_q <= bus.opcode;
      if (state == S_MEM && state_nx == S_MEM) wait_cnt <= wait_cnt + 8'd1;
      else                                     wait_cnt <= '0;
      if (retire_now) retired_q <= retired_q + RETIRE_W'(1);
    end
  end

  always_comb begin
    state_nx   = state;
    retire_now = 1'b0;
    timeout    = 1'b0;
    eoi_state  = bus.enable ? S_FETCH : S_IDLE;
    case (state)
      S_IDLE:   if (bus.enable) state_nx = S_FETCH;
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: begin
        if (live_cls == C_ILL) begin
`ifdef MC_ILLEGAL_TRAP_EN
          state_nx = S_HALT;
`else
          state_nx = eoi_state;
`endif
        end else begin
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls)
          C_LDUR, C_STUR: state_nx = S_MEM;
          C_CBZ: begin
            state_nx   = eoi_state;
            retire_now = 1'b1;
          end
          default: state_nx = S_WB;
        endcase
      end
      S_MEM: begin
        // An ack in the final wait cycle still completes the transfer.
        if (bus.mem_ack) begin
          if (cls == C_LDUR) begin
            state_nx = S_WB;
          end else begin
            state_nx   = eoi_state;
            retire_now = 1'b1;
          end
        end else if (wait_cnt == 8'(MEM_WAIT_MAX - 1)) begin
          state_nx = eoi_state;
          timeout  = 1'b1;
        end
      end
      S_WB: begin
        state_nx   = eoi_state;
        retire_now = 1'b1;
      end
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus.pc_write     = 1'b0;
    bus.pc_src       = 1'b0;
    bus.ir_write     = 1'b0;
    bus.reg_write_rf = 1'b0;
    bus.mem_read_dm  = 1'b0;
    bus.mem_write_dm = 1'b0;
    bus.mux2         = 1'b0;
    bus.mux3         = 1'b0;
    bus.alu_op       = 3'b000;
    bus.branch       = 1'b0;
    case (state)
      S_FETCH: begin
        bus.ir_write = 1'b1;
        bus.pc_write = 1'b1;
      end
      S_EXEC: begin
        bus.alu_op = alu_q;
        bus.mux3   = imm_sel;
        if (cls == C_CBZ) begin
          bus.branch   = 1'b1;
          bus.pc_write = bus.zero;
          bus.pc_src   = bus.zero;
        end
      end
      S_MEM: begin
        bus.alu_op       = 3'b010;
        bus.mux3         = 1'b1;
        bus.mem_read_dm  = (cls == C_LDUR);
        bus.mem_write_dm = (cls == C_STUR);
      end
      S_WB: begin
        bus.reg_write_rf = 1'b1;
        bus.mux2         = (cls == C_LDUR);
        bus.alu_op       = alu_q;
        bus.mux3         = imm_sel;
      end
      default: ;
    endcase
  end

  assign bus.mem_err   = mem_err_q;
  assign bus.retired   = retired_q;
  assign bus.state_dbg = state;
`ifdef MC_ILLEGAL_TRAP_EN
  assign bus.illegal_op = (state == S_HALT);
`endif

endmodule

// File: tb/tb_multicycle_control_sequencer.sv
// Bench for multicycle_control_sequencer: per-cycle expected control words from a
// table of instructions, scoreboard queue checked every falling edge, plus corner sequences.
module tb_multicycle_control_sequencer;

  localparam int MAXW = 15;
  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_CBZ = 4, K_ILL = 5;
  localparam int NV = 13;

  typedef struct {
    logic [9:0] opcode;
    logic       zero;
    int         ack_delay;
    logic       en;
    logic       noise;
    int         kind;
    logic [2:0] alu;
  } vec_t;

  logic clk;
  logic reset;
  multicycle_control_sequencer_if #(.RETIRE_W(32)) bus ();

  multicycle_control_sequencer #(.MEM_WAIT_MAX(MAXW), .RETIRE_W(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [12:0] exp_q[$];
  string       name_q[$];
  logic        pending_err = 1'b0;
  logic [31:0] exp_ret = '0;
  vec_t        tbl[NV];
  logic [12:0] act_w;

  assign act_w = {bus.pc_write, bus.pc_src, bus.ir_write, bus.reg_write_rf,
                  bus.mem_read_dm, bus.mem_write_dm, bus.mux2, bus.mux3,
                  bus.alu_op, bus.branch, bus.mem_err};

  function automatic logic [12:0] mk(input logic pcw, input logic pcs, input logic irw,
                                     input logic rw, input logic mr, input logic mw,
                                     input logic m2, input logic m3, input logic [2:0] alu,
                                     input logic br);
    return {pcw, pcs, irw, rw, mr, mw, m2, m3, alu, br, 1'b0};
  endfunction

  function automatic vec_t mkv(input logic [9:0] op, input int kind, input logic [2:0] alu,
                               input logic zero, input int dly, input logic en,
                               input logic noise);
    vec_t v;
    v.opcode = op; v.kind = kind; v.alu = alu; v.zero = zero;
    v.ack_delay = dly; v.en = en; v.noise = noise;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // scoreboard: one expected control word per clock cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [12:0] e;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      total++;
      if (act_w !== e) begin
        bad++;
        $display("FAIL %s: ctrl got %b expected %b at %0t", n, act_w, e, $time);
      end
    end
  end

  // driver: one call = one clock cycle, entered #1 after a rising edge
  task automatic cyc(input logic [12:0] w, input logic ack, input logic en, input string nm);
    bus.mem_ack = ack;
    bus.enable  = en;
    exp_q.push_back(w | {12'b0, pending_err});
    name_q.push_back(nm);
    pending_err = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int nmem;
    logic mm;
    bus.opcode = v.opcode;
    bus.zero   = v.zero;
    mm = (v.kind == K_LD) || (v.kind == K_ST);
    cyc(mk(1,0,1,0,0,0,0,0,3'b000,0), v.noise, v.en, {nm, "_fetch"});
    cyc(13'b0, v.noise, v.en, {nm, "_decode"});
    if (v.kind == K_ILL) begin
      check({nm, "_retired"}, 64'(bus.retired), 64'(exp_ret));
      return;
    end
    if (v.kind == K_CBZ)
      cyc(mk(v.zero,v.zero,0,0,0,0,0,0,v.alu,1), v.noise, v.en, {nm, "_exec"});
    else
      cyc(mk(0,0,0,0,0,0,0,(v.kind != K_R),v.alu,0), v.noise, v.en, {nm, "_exec"});
    if (mm) begin
      nmem = (v.ack_delay >= MAXW) ? MAXW : v.ack_delay + 1;
      for (int m = 0; m < nmem; m++)
        cyc(mk(0,0,0,0,(v.kind == K_LD),(v.kind == K_ST),0,1,3'b010,0),
            (m == v.ack_delay), v.en, {nm, "_mem"});
      if (v.ack_delay >= MAXW) begin
        pending_err = 1'b1;
        check({nm, "_retired"}, 64'(bus.retired), 64'(exp_ret));
        return;
      end
    end
    if (v.kind != K_CBZ && v.kind != K_ST)
      cyc(mk(0,0,0,1,0,0,(v.kind == K_LD),(v.kind != K_R),v.alu,0), v.noise, v.en,
          {nm, "_wb"});
    exp_ret = exp_ret + 32'd1;
    check({nm, "_retired"}, 64'(bus.retired), 64'(exp_ret));
  endtask

  initial begin
    tbl[0]  = mkv(10'b1000101100, K_R,   3'b010, 0, 0,  1, 0);
    tbl[1]  = mkv(10'b1100101100, K_R,   3'b110, 0, 0,  1, 1);
    tbl[2]  = mkv(10'b1000101000, K_R,   3'b000, 1, 0,  1, 0);
    tbl[3]  = mkv(10'b1010101000, K_R,   3'b001, 0, 0,  1, 0);
    tbl[4]  = mkv(10'b1001000100, K_I,   3'b010, 0, 0,  1, 0);
    tbl[5]  = mkv(10'b1111100001, K_LD,  3'b010, 0, 3,  1, 0);
    tbl[6]  = mkv(10'b1111100000, K_ST,  3'b010, 0, 0,  1, 0);
    tbl[7]  = mkv(10'b1011010011, K_CBZ, 3'b111, 1, 0,  1, 0);
    tbl[8]  = mkv(10'b1011010000, K_CBZ, 3'b111, 0, 0,  0, 0);
    tbl[9]  = mkv(10'b1111100000, K_ST,  3'b010, 0, 99, 1, 0);
    tbl[10] = mkv(10'b1111100001, K_LD,  3'b010, 0, 14, 1, 0);
`ifdef MC_ILLEGAL_TRAP_EN
    tbl[11] = mkv(10'b1000101100, K_R,   3'b010, 0, 0,  1, 0);
`else
    tbl[11] = mkv(10'b0000000000, K_ILL, 3'b000, 0, 0,  1, 0);
`endif
    tbl[12] = mkv(10'b1000101100, K_R,   3'b010, 0, 0,  0, 1);

    reset = 1'b0;
    bus.enable = 1'b0; bus.opcode = '0; bus.zero = 1'b0; bus.mem_ack = 1'b0;
    @(negedge clk);
    check("reset_ctrl", 64'(act_w), 64'd0);
    check("reset_retired", 64'(bus.retired), 64'd0);
    check("reset_state", 64'(bus.state_dbg), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc(13'b0, 1'b1, 1'b0, "idle_ack_ignored");
    cyc(13'b0, 1'b0, 1'b1, "idle_go");

    for (int i = 0; i < NV; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
      if (!tbl[i].en) begin
        cyc(13'b0, 1'b0, 1'b0, $sformatf("vec%0d_idle", i));
        cyc(13'b0, 1'b0, 1'b1, $sformatf("vec%0d_idle_go", i));
      end
    end

    for (int r = 0; r < 12; r++) begin
      vec_t v;
      v = tbl[$urandom_range(0, 7)];
      v.ack_delay = $urandom_range(0, 4);
      v.zero      = 1'($urandom_range(0, 1));
      v.noise     = 1'($urandom_range(0, 1));
      v.en        = 1'b1;
      run_vec(v, $sformatf("rnd%0d", r));
    end

    // reset in the middle of a store: request must drop without a clock edge
    bus.opcode = 10'b1111100000;
    bus.mem_ack = 1'b0;
    bus.enable = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("st_mem_req", 64'(bus.mem_write_dm), 64'd1);
    reset = 1'b0;
    #1;
    check("rst_async_mw", 64'(bus.mem_write_dm), 64'd0);
    check("rst_async_ctrl", 64'(act_w), 64'd0);
    check("rst_async_state", 64'(bus.state_dbg), 64'd0);
    check("rst_async_retired", 64'(bus.retired), 64'd0);
    exp_ret = '0;
    bus.enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc(13'b0, 1'b0, 1'b1, "post_rst_go");
    run_vec(tbl[0], "post_rst_add");

`ifdef MC_ILLEGAL_TRAP_EN
    bus.opcode = 10'b0000000000;
    cyc(mk(1,0,1,0,0,0,0,0,3'b000,0), 1'b0, 1'b1, "trap_fetch");
    cyc(13'b0, 1'b0, 1'b1, "trap_decode");
    for (int h = 0; h < 4; h++) begin
      check("trap_illegal_op", 64'(bus.illegal_op), 64'd1);
      cyc(13'b0, 1'b0, 1'b1, "trap_halt");
    end
    check("trap_retired", 64'(bus.retired), 64'(exp_ret));
    reset = 1'b0;
    #1;
    check("trap_cleared", 64'(bus.illegal_op), 64'd0);
    reset = 1'b1;
`endif

    @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
